// File: rtl/turbo_enc_sched.sv
// turbo_enc_sched: fetches K systematic bits for one RSC encoder,
// then drives three trellis-termination beats, with downstream backpressure.
module turbo_enc_sched #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int ADDR_W  = 13
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start,
  input  logic              k_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  input  logic              out_ready,
  output logic              ck,
  output logic              enc_en,
  output logic              enc_clr,
  output logic              term,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              start_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] KS  = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] KL  = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] k_len;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] enc_cnt;
  logic [1:0]        tail_cnt;
  logic              first_q;
  logic              inflight;

  logic [1:0] fifo_mem;
  logic [1:0] fifo_cnt;
  logic       wr_ptr;
  logic       rd_ptr;

  logic       accept;
  logic       push;
  logic       pop;
  logic       fetch_ok;
  logic       tail_beat;
  logic [2:0] occ;

  assign accept    = (state == S_IDLE) & start;
  assign push      = inflight;
  assign pop       = (state == S_RUN) & (fifo_cnt != 2'd0) & out_ready;
  assign tail_beat = (state == S_TAIL) & out_ready;

  // Reserve a slot for the read still in flight so the FIFO cannot overflow.
  assign occ = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign fetch_ok = (state == S_RUN)
                  & (rd_cnt < k_len)
                  & (occ < 3'd2);

  assign rd_en      = fetch_ok;
  assign rd_addr    = rd_cnt;
  assign enc_clr    = (state == S_RUN) & first_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign start_drop = start & busy;

  always_comb begin
    enc_en   = 1'b0;
    ck       = 1'b0;
    term     = 1'b0;
    out_last = 1'b0;
    unique case (state)
      S_RUN: begin
        enc_en = pop;
        ck     = (fifo_cnt != 2'd0) & fifo_mem[rd_ptr];
      end
      S_TAIL: begin
        enc_en   = out_ready;
        term     = 1'b1;
        out_last = tail_beat & (tail_cnt == 2'd2);
      end
      S_IDLE: ;
      S_DONE: ;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (pop && (enc_cnt == k_len - ONE))
          state_nxt = S_TAIL;
      end
      S_TAIL: begin
        if (tail_beat && (tail_cnt == 2'd2))
          state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= S_IDLE;
      first_q  <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      first_q  <= accept;
      inflight <= fetch_ok;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      k_len    <= '0;
      rd_cnt   <= '0;
      enc_cnt  <= '0;
      tail_cnt <= 2'd0;
    end else if (accept) begin
      k_len    <= k_sel ? KL : KS;
      rd_cnt   <= '0;
      enc_cnt  <= '0;
      tail_cnt <= 2'd0;
    end else begin
      if (fetch_ok)  rd_cnt   <= rd_cnt + ONE;
      if (pop)       enc_cnt  <= enc_cnt + ONE;
      if (tail_beat) tail_cnt <= tail_cnt + 2'd1;
    end
  end

  // Two-entry skid buffer between the buffer read port and the encoder.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      fifo_mem <= 2'b00;
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_turbo_enc_sched.sv
// tb_turbo_enc_sched: randomized bench with a block-level reference model
// of fetch order, beat sequence and completion timing.
module tb_turbo_enc_sched;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          aclr;
  logic          start;
  logic          k_sel;
  logic          out_ready;
  logic          rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          ck;
  logic          enc_en;
  logic          enc_clr;
  logic          term;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          start_drop;

  turbo_enc_sched dut (
    .clk        (clk),
    .aclr       (aclr),
    .start      (start),
    .k_sel      (k_sel),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_ready  (out_ready),
    .ck         (ck),
    .enc_en     (enc_en),
    .enc_clr    (enc_clr),
    .term       (term),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  bit mem [8192];

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // reference model: phase 0 idle, 1 active, 2 done
  int ph, mk, t, reads, beats, fifo, pend;

  // observed statistics
  int n_rd = 0, n_en = 0, n_drop = 0, n_done = 0;
  int last_done = 0, last_ol = 0, last_clr = 0;
  int obs_occ = 0, obs_pend = 0;

  int drop_a = -1, drop_b = -1, abort_at = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = 0; mk = 0; t = 0; reads = 0; beats = 0;
    fifo = 0; pend = 0;
    obs_occ = 0; obs_pend = 0;
  endtask

  task automatic compare();
    logic e_en, e_pop, e_rd, e_clr, e_term, e_last;
    logic e_done, e_busy, e_drop, e_ck;
    if (aclr) begin
      chk("reset_out",
          {rd_en, rd_addr, ck, enc_en, enc_clr, term,
           out_last, busy, done, start_drop}, 0);
      model_reset();
      return;
    end
    e_en   = (ph == 1) && out_ready &&
             ((beats < mk) ? (fifo > 0) : (beats < mk + 3));
    e_pop  = e_en && (beats < mk);
    e_rd   = (ph == 1) && (reads < mk) &&
             ((fifo + pend - (e_pop ? 1 : 0)) < 2);
    e_clr  = (ph == 1) && (t == 1);
    e_term = (ph == 1) && (beats >= mk);
    e_last = e_en && (beats == mk + 2);
    e_done = (ph == 2);
    e_busy = (ph != 0);
    e_drop = start && (ph != 0);
    e_ck   = e_pop ? mem[beats] : 1'b0;
    chk("ctl[busy,clr,en,rd,term,last,done,drop]",
        {busy, enc_clr, enc_en, rd_en, term, out_last, done, start_drop},
        {e_busy, e_clr, e_en, e_rd, e_term, e_last, e_done, e_drop});
    if (e_rd) chk("rd_addr", rd_addr, reads);
    if (e_en || e_term) chk("ck", ck, e_ck);

    n_rd   += rd_en;
    n_en   += enc_en;
    n_drop += start_drop;
    if (done)     begin n_done++; last_done = cyc; end
    if (out_last) last_ol  = cyc;
    if (enc_clr)  last_clr = cyc;
    obs_occ  = obs_occ + obs_pend - ((enc_en && !term) ? 1 : 0);
    obs_pend = rd_en;
    chk("fifo_occ_le2", obs_occ <= 2, 1);

    case (ph)
      0: if (start) begin
        ph = 1; mk = k_sel ? 6144 : 1056;
        t = 0; reads = 0; beats = 0; fifo = 0; pend = 0;
      end
      1: begin
        fifo  = fifo + pend - (e_pop ? 1 : 0);
        pend  = e_rd;
        reads += e_rd;
        beats += e_en;
        if (beats == mk + 3) ph = 2;
      end
      default: ph = 0;
    endcase
    t++;
  endtask

  task automatic step(input logic st, input logic ks, input logic ordy);
    @(posedge clk);
    #1;
    cyc++;
    start = st;
    k_sel = ks;
    out_ready = ordy;
    @(negedge clk);
    compare();
  endtask

  function automatic logic or_val(input int mode, input int i);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      2:       return !(i >= 5 && i <= 24);
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_abort();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    out_ready = 1'b1;
    #1 aclr = 1'b1;
    #1;
    chk("abort_out_zero",
        {rd_en, ck, enc_en, enc_clr, term, out_last, busy, done}, 0);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
    aclr = 1'b0;
    @(negedge clk);
    compare();
  endtask

  task automatic run_block(input logic ks, input int mode,
                           input int budget, output int s0);
    int nd;
    bit dr;
    foreach (mem[i]) mem[i] = 1'($urandom);
    nd = n_done;
    step(1'b1, ks, or_val(mode, 0));
    s0 = cyc;
    for (int i = 1; i <= budget && n_done == nd; i++) begin
      if (i == abort_at) begin
        do_abort();
        return;
      end
      dr = (i == drop_a) || (i == drop_b);
      step(dr, dr ? ~ks : ks, or_val(mode, i));
    end
    chk("done_seen", n_done - nd, 1);
  endtask

  initial begin
    int s, s2, r0, e0, d0, nd;
    aclr = 1'b1; start = 1'b0; k_sel = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1 aclr = 1'b0;

    // K=1056, no backpressure
    r0 = n_rd; e0 = n_en;
    run_block(1'b0, 0, 1200, s);
    chk("t1_reads", n_rd - r0, 1056);
    chk("t1_beats", n_en - e0, 1059);
    chk("t1_last_cyc", last_ol - s, 1061);
    chk("t1_done_cyc", last_done - s, 1062);

    // K=6144 then back-to-back K=1056 with random backpressure
    r0 = n_rd; e0 = n_en;
    run_block(1'b1, 0, 6300, s);
    chk("t2_reads", n_rd - r0, 6144);
    chk("t2_beats", n_en - e0, 6147);
    chk("t2_done_cyc", last_done - s, 6150);
    r0 = n_rd; e0 = n_en;
    run_block(1'b0, 1, 4000, s2);
    chk("t2_b2b_clr_cyc", last_clr - s, 6152);
    chk("t3_reads", n_rd - r0, 1056);
    chk("t3_beats", n_en - e0, 1059);

    // 20-cycle stall from cycle 5
    r0 = n_rd; e0 = n_en;
    run_block(1'b0, 2, 1300, s);
    chk("t4_reads", n_rd - r0, 1056);
    chk("t4_beats", n_en - e0, 1059);
    chk("t4_done_cyc", last_done - s, 1082);

    // starts while busy
    d0 = n_drop;
    drop_a = 100; drop_b = 1061;
    run_block(1'b0, 0, 1200, s);
    drop_a = -1; drop_b = -1;
    chk("t5_drops", n_drop - d0, 2);
    chk("t5_done_cyc", last_done - s, 1062);

    // abort mid-block, then a clean block
    nd = n_done;
    abort_at = 500;
    run_block(1'b0, 0, 1200, s);
    abort_at = -1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom));
    chk("t6_no_done", n_done - nd, 0);
    r0 = n_rd; e0 = n_en;
    run_block(1'b0, 1, 4000, s);
    chk("t6_clr_cyc", last_clr - s, 1);
    chk("t6_reads", n_rd - r0, 1056);
    chk("t6_beats", n_en - e0, 1059);

    // large block under random backpressure
    r0 = n_rd; e0 = n_en;
    run_block(1'b1, 1, 20000, s);
    chk("t7_reads", n_rd - r0, 6144);
    chk("t7_beats", n_en - e0, 6147);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/turbo_enc_sched.md
Name: turbo_enc_sched

Overview:
- Sequencer for one constituent RSC encoder in the turbo-encode path.
- On a block start it latches the block size (1056 or 6144), fetches K systematic bits from a synchronous-read bit buffer, and presents them to the encoder one beat at a time.
- It then drives 3 trellis-termination beats and signals completion.
- It handles downstream backpressure through a 2-entry skid FIFO, which absorbs the 1-cycle read latency without losing throughput.

Parameters:
- K_SMALL, 1056, block length selected when k_sel=0
- K_LARGE, 6144, block length selected when k_sel=1
- ADDR_W, 13, buffer address and counter width; must hold K_LARGE

Ports:
- clk  in  1  single clock; all registers on its rising edge
- aclr  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle block-start pulse (data_ready from the interleaver)
- k_sel  in  1  block size, sampled with start; 0=K_SMALL, 1=K_LARGE
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer bit address; valid while rd_en=1
- rd_data  in  1  buffer bit; valid exactly 1 cycle after rd_en
- out_ready  in  1  downstream can accept an encoder output beat this cycle
- ck  out  1  bit to encoder; forced 0 in TAIL
- enc_en  out  1  encoder clock enable; also the output-beat valid (xk/zk valid while high)
- enc_clr  out  1  synchronous clear of the encoder shift register
- term  out  1  termination mux select (feedback drives the input)
- out_last  out  1  high on the final (3rd) tail beat
- busy  out  1  block in progress
- done  out  1  one-cycle completion pulse
- start_drop  out  1  one-cycle pulse: start arrived while busy and was ignored

Behaviour:
- Reset (aclr=1, asynchronous): state=IDLE; all counters, the FIFO and the in-flight flag clear; every output is 0.
- States: IDLE -> RUN -> TAIL -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - start=1 latches K from k_sel, clears rd_cnt and enc_cnt, and goes to RUN.
- RUN, first cycle: enc_clr=1 (exactly one cycle per block); enc_en=0 in that cycle.
- Fetch rule: rd_en=1 when both hold:
  - rd_cnt<K
  - (fifo_cnt + inflight - pop) < 2, where pop is enc_en this cycle.
- Fetch bookkeeping:
  - rd_addr=rd_cnt; rd_cnt increments on each read.
  - inflight is set the cycle after rd_en; rd_data is pushed into the FIFO at the end of that cycle.
- Beat rule in RUN: enc_en = (fifo_cnt>0) & out_ready. ck = FIFO head; pop on enc_en; enc_cnt increments.
- Stall: with out_ready=0, nothing is popped and reads stop once occupancy+inflight=2. No bit is dropped or duplicated.
- RUN -> TAIL when enc_cnt reaches K. That transition is the cycle after the K-th enc_en.
- TAIL:
  - term=1, ck=0, enc_en=out_ready, rd_en=0.
  - Counts exactly 3 enc_en beats; out_last=1 with the 3rd.
  - Goes to DONE after the 3rd beat.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in RUN, TAIL and DONE.
- Timing with out_ready held 1 and start in cycle 0:
  - rd_en in cycles 1..K, addresses 0..K-1.
  - enc_en data beats in cycles 3..K+2.
  - Tail beats in K+3..K+5; out_last in K+5.
  - done in K+6; busy high in cycles 1..K+6.
  - A new start is accepted from cycle K+7.
- start while busy: ignored, start_drop=1 that cycle, the latched K is unchanged.
- start and out_ready are independent; out_ready=0 in IDLE has no effect.
- Totals per block: exactly K reads and exactly K+3 enc_en beats, independent of out_ready pattern.
- FIFO never exceeds 2 entries. Overflow is impossible by construction; verification asserts it.
- aclr mid-block aborts immediately with no done pulse. The next start begins cleanly with enc_clr.

Test Plan:
1. k_sel=0 start, out_ready=1 -> 1056 rd_en (addr 0..1055), 1059 enc_en, ck matches buffer order, out_last in cycle 1061, done in cycle 1062, busy low in cycle 1063.
2. k_sel=1 start, out_ready=1 -> 6144 reads, 6147 beats, done in cycle 6150; a back-to-back start in cycle 6151 is accepted with enc_clr in cycle 6152.
3. K=1056, out_ready pseudo-random 50% -> bit sequence on enc_en beats equals buffer contents 0..1055 then three term=1/ck=0 beats; FIFO occupancy ≤2 throughout.
4. out_ready=0 for 20 cycles starting in cycle 5 -> rd_en stops after occupancy reaches 2, enc_en=0, counters hold; resume with no lost or duplicated bits.
5. start pulses in cycles 100 and 1061 of a K=1056 block -> start_drop=1 in both cycles, block still ends with done in cycle 1062.
6. aclr asserted in cycle 500 of a block, mid-clock -> outputs 0 immediately, no done; a start after release runs a full correct 1056-bit block.
